i2c_cmd_arbiter: RTL

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

---
 rtl/i2c_cmd_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/i2c_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of an I2C command controller.
// Latches the granted command word, drives oGO until the controller signals
// end of transfer, retries on NACK and bounds each transfer with a timeout.
// The retry counter is 2 bits wide, so MAX_RETRY is meaningful only up to 3.
// The timeout counter is 20 bits wide, so TIMEOUT_CYC should lie in 1..2**20.
module i2c_cmd_arbiter #(
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [1:0]  iREQ,
    input  logic [23:0] iDATA0,
    input  logic [23:0] iDATA1,
    output logic [1:0]  oGNT,
    output logic [1:0]  oDONE,
    output logic [1:0]  oERR,
    output logic [23:0] oI2C_DATA,
    output logic        oGO,
    input  logic        iEND,
    input  logic        iACK,
    output logic        oBUSY
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitEnd,
        StRelease,
        StReport
    } state_t;

    // Timeout fires on the cycle the counter would reach TIMEOUT_CYC, so oGO
    // is high for exactly TIMEOUT_CYC cycles.
    localparam logic [19:0] ToLimit   = (TIMEOUT_CYC > 0) ? 20'(TIMEOUT_CYC - 1) : 20'd0;
    localparam logic [19:0] ToMax     = 20'hFFFFF;
    localparam logic [1:0]  MaxRetry  = 2'(MAX_RETRY);

    state_t      state;
    logic        endMeta, endSync;
    logic        ackMeta, ackSync;
    logic        lastServed;
    logic        gIdx;
    logic [1:0]  retryCnt;
    logic [19:0] toCnt;
    logic        ackLat;
    logic        errFlag;
    logic        pick;

    // Two-flop synchronizers for the controller's asynchronous handshake flags.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            endMeta <= 1'b0;
            endSync <= 1'b0;
            ackMeta <= 1'b0;
            ackSync <= 1'b0;
        end else begin
            endMeta <= iEND;
            endSync <= endMeta;
            ackMeta <= iACK;
            ackSync <= ackMeta;
        end
    end

    // Round-robin choice: on a tie the requester not served last wins.
    always_comb begin
        pick = 1'b0;
        if (iREQ == 2'b11) begin
            pick = ~lastServed;
        end else begin
            pick = iREQ[1];
        end
    end

    // Arbitration / transfer FSM with registered outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= StIdle;
            oGO        <= 1'b0;
            oGNT       <= 2'b00;
            oDONE      <= 2'b00;
            oERR       <= 2'b00;
            oI2C_DATA  <= 24'd0;
            lastServed <= 1'b1;
            gIdx       <= 1'b0;
            retryCnt   <= 2'd0;
            toCnt      <= 20'd0;
            ackLat     <= 1'b0;
            errFlag    <= 1'b0;
        end else begin
            oDONE <= 2'b00;
            oERR  <= 2'b00;
            case (state)
                StIdle: begin
                    if (|iREQ) begin
                        gIdx      <= pick;
                        oGNT      <= pick ? 2'b10 : 2'b01;
                        oI2C_DATA <= pick ? iDATA1 : iDATA0;
                        retryCnt  <= 2'd0;
                        errFlag   <= 1'b0;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    oGO   <= 1'b1;
                    toCnt <= 20'd0;
                    state <= StWaitEnd;
                end
                StWaitEnd: begin
                    if (endSync) begin
                        ackLat <= ackSync;
                        oGO    <= 1'b0;
                        state  <= StRelease;
                    end else if (toCnt >= ToLimit) begin
                        oGO     <= 1'b0;
                        errFlag <= 1'b1;
                        state   <= StRelease;
                    end else if (toCnt != ToMax) begin
                        toCnt <= toCnt + 20'd1;
                    end
                end
                StRelease: begin
                    if (!endSync) begin
                        if (errFlag) begin
                            // Timeout: report error, never retry.
                            oDONE <= oGNT;
                            oERR  <= oGNT;
                            state <= StReport;
                        end else if (!ackLat) begin
                            oDONE <= oGNT;
                            state <= StReport;
                        end else if (retryCnt < MaxRetry) begin
                            retryCnt <= retryCnt + 2'd1;
                            state    <= StIssue;
                        end else begin
                            oDONE <= oGNT;
                            oERR  <= oGNT;
                            state <= StReport;
                        end
                    end
                end
                StReport: begin
                    lastServed <= gIdx;
                    oGNT       <= 2'b00;
                    state      <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign oBUSY = (state != StIdle);

endmodule
